led_chase_monitor: RTL

- Receive-side checker for the 8-bit one-hot LED chase bus driven by the LED mode drivers.
- Samples the bus, decodes the lit LED index and emits a beat pulse per new LED.
- Measures ON and OFF durations and checks one-hot legality and index order (+1 mod 8).
- Used on-board as a self-test monitor; error flags feed a status LED/UART later.

---
 rtl/led_chase_monitor.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/led_chase_monitor.sv
// Receive-side checker for an 8-bit one-hot LED chase bus: decodes the lit index,
// times ON/OFF periods, checks order and legality. Define LED_MON_STATS_EN to add beat_total.
module led_chase_monitor #(
    parameter int ON_CYCLES  = 300,
    parameter int OFF_CYCLES = 301,
    parameter int TOL        = 0,
    parameter int CNT_W      = 10,
    parameter int LOCK_BEATS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  led_in,
    input  logic        err_clr,
    output logic [2:0]  led_idx,
    output logic        idx_valid,
    output logic        beat,
    output logic        err_onehot,
    output logic        err_seq,
    output logic        err_timing,
    output logic        locked
`ifdef LED_MON_STATS_EN
    ,
    output logic [15:0] beat_total
`endif
);

    localparam int LOCK_W = $clog2(LOCK_BEATS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_BEATS);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

    state_t             state_q, state_d;
    logic [7:0]         led_q;
    logic [CNT_W-1:0]   on_cnt_q, on_cnt_d;
    logic [CNT_W-1:0]   off_cnt_q, off_cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic               beat_q, beat_d;
    logic               on_ok_q, on_ok_d;
    logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic               err_onehot_q, err_onehot_d;
    logic               err_seq_q, err_seq_d;
    logic               err_timing_q, err_timing_d;

    logic               is_onehot;
    logic [2:0]         enc;
    logic [2:0]         idx_next;
    logic               set_eo, set_es, set_et;
    logic               off_ok, seq_ok, clean;

    // A saturated counter can never pass, even if the window reaches the ceiling.
    function automatic logic dur_ok(input logic [CNT_W-1:0] cnt, input int n);
        return (cnt != CNT_MAX) && (int'(cnt) >= n - TOL) && (int'(cnt) <= n + TOL);
    endfunction

    always_comb begin
        is_onehot = (led_q != 8'd0) && ((led_q & (led_q - 8'd1)) == 8'd0);
        enc       = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (led_q[i]) enc = 3'(i);
        end
        idx_next = idx_q + 3'd1;
    end

    always_comb begin
        // NOTE: every variable gets a default first, so no branch can infer a latch.
        state_d    = state_q;
        on_cnt_d   = on_cnt_q;
        off_cnt_d  = off_cnt_q;
        idx_d      = idx_q;
        beat_d     = 1'b0;
        on_ok_d    = on_ok_q;
        lock_cnt_d = lock_cnt_q;
        set_eo     = 1'b0;
        set_es     = 1'b0;
        set_et     = 1'b0;
        off_ok     = 1'b0;
        seq_ok     = 1'b0;
        clean      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (led_q != 8'd0) begin
                    if (is_onehot) begin
                        state_d  = S_ON;
                        on_cnt_d = CNT_W'(1);
                        idx_d    = enc;
                        beat_d   = 1'b1;
                    end else begin
                        set_eo = 1'b1;
                    end
                end
            end
            S_ON: begin
                if (led_q == (8'd1 << idx_q)) begin
                    on_cnt_d = (on_cnt_q == CNT_MAX) ? CNT_MAX : on_cnt_q + CNT_W'(1);
                end else if (led_q == 8'd0) begin
                    on_ok_d   = dur_ok(on_cnt_q, ON_CYCLES);
                    set_et    = !on_ok_d;
                    state_d   = S_OFF;
                    off_cnt_d = CNT_W'(1);
                end else begin
                    set_eo  = !is_onehot;
                    set_es  = is_onehot;
                    state_d = S_IDLE;
                end
            end
            S_OFF: begin
                if (led_q == 8'd0) begin
                    off_cnt_d = (off_cnt_q == CNT_MAX) ? CNT_MAX : off_cnt_q + CNT_W'(1);
                end else begin
                    off_ok = dur_ok(off_cnt_q, OFF_CYCLES);
                    set_et = !off_ok;
                    if (is_onehot) begin
                        seq_ok   = (enc == idx_next);
                        set_es   = !seq_ok;
                        state_d  = S_ON;
                        on_cnt_d = CNT_W'(1);
                        idx_d    = enc;
                        beat_d   = 1'b1;
                        clean    = on_ok_q && off_ok && seq_ok;
                    end else begin
                        set_eo  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (set_eo || set_es || set_et) begin
            lock_cnt_d = '0;
        end else if (clean && lock_cnt_q != LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end

        // A new error in the clear cycle wins over err_clr.
        err_onehot_d = (err_onehot_q & ~err_clr) | set_eo;
        err_seq_d    = (err_seq_q    & ~err_clr) | set_es;
        err_timing_d = (err_timing_q & ~err_clr) | set_et;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            led_q        <= '0;
            on_cnt_q     <= '0;
            off_cnt_q    <= '0;
            idx_q        <= '0;
            beat_q       <= 1'b0;
            on_ok_q      <= 1'b0;
            lock_cnt_q   <= '0;
            err_onehot_q <= 1'b0;
            err_seq_q    <= 1'b0;
            err_timing_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            led_q        <= led_in;
            on_cnt_q     <= on_cnt_d;
            off_cnt_q    <= off_cnt_d;
            idx_q        <= idx_d;
            beat_q       <= beat_d;
            on_ok_q      <= on_ok_d;
            lock_cnt_q   <= lock_cnt_d;
            err_onehot_q <= err_onehot_d;
            err_seq_q    <= err_seq_d;
            err_timing_q <= err_timing_d;
        end
    end

`ifdef LED_MON_STATS_EN
    logic [15:0] beat_total_q, beat_total_d;

    always_comb begin
        beat_total_d = (err_clr ? 16'd0 : beat_total_q) + (clean ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) beat_total_q <= '0;
        else     beat_total_q <= beat_total_d;
    end

    assign beat_total = beat_total_q;
`endif

    assign led_idx    = idx_q;
    assign idx_valid  = (state_q == S_ON);
    assign beat       = beat_q;
    assign err_onehot = err_onehot_q;
    assign err_seq    = err_seq_q;
    assign err_timing = err_timing_q;
    assign locked     = (lock_cnt_q == LOCK_MAX);

endmodule
